// File: rtl/gcd_ctrl_if.sv
// Control/status bundle between the GCD sequencer and its datapath/requester.
// Latency: none, plain wires.
// Backpressure: go_i/done_o form a four-phase handshake; no other flow control.
interface gcd_ctrl_if;
  logic       go_i;
  logic       x_neq_y;
  logic       x_lt_y;
  logic       x_sel;
  logic       x_ld;
  logic       y_sel;
  logic       y_ld;
  logic       d_ld;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [3:0] iter_o;

  // Requester + datapath side: raises go, reports comparator flags.
  modport master (
    output go_i, x_neq_y, x_lt_y,
    input  x_sel, x_ld, y_sel, y_ld, d_ld, busy_o, done_o, err_o, iter_o
  );

  // Controller side.
  modport slave (
    input  go_i, x_neq_y, x_lt_y,
    output x_sel, x_ld, y_sel, y_ld, d_ld, busy_o, done_o, err_o, iter_o
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Subtractive-GCD controller: sequences X/Y loads and subtracts, aborts after ITER_MAX steps.
// Latency: DONE entered 2k+3 edges after go is sampled in IDLE (k = subtract steps).
// Backpressure: result/error held in DONE/ERR until go_i is seen low; no restart before that.
module gcd_ctrl #(
  parameter int unsigned ITER_MAX = 15
) (
  input  logic     CLK,
  input  logic     RESET,
  gcd_ctrl_if.slave bus
);

  localparam logic [3:0] ITER_LIM = 4'(ITER_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    CHECK  = 3'd2,
    UPD_X  = 3'd3,
    UPD_Y  = 3'd4,
    LOAD_D = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] iter_q;
  logic [3:0] iter_nxt;

  logic       x_sel_q;
  logic       x_ld_q;
  logic       y_sel_q;
  logic       y_ld_q;
  logic       d_ld_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  // Next-state and step-counter selection; CHECK guards the limit so iter never wraps.
  always_comb begin
    state_nxt = IDLE;
    iter_nxt  = iter_q;
    case (state_q)
      IDLE:    state_nxt = bus.go_i ? INIT : IDLE;
      INIT:    state_nxt = CHECK;
      CHECK: begin
        if (!bus.x_neq_y)          state_nxt = LOAD_D;
        else if (iter_q == ITER_LIM) state_nxt = ERR;
        else if (bus.x_lt_y)       state_nxt = UPD_Y;
        else                       state_nxt = UPD_X;
      end
      UPD_X:   state_nxt = CHECK;
      UPD_Y:   state_nxt = CHECK;
      LOAD_D:  state_nxt = DONE;
      DONE:    state_nxt = bus.go_i ? DONE : IDLE;
      ERR:     state_nxt = bus.go_i ? ERR : IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == INIT) begin
      iter_nxt = 4'd0;
    end else if ((state_nxt == UPD_X) || (state_nxt == UPD_Y)) begin
      iter_nxt = iter_q + 4'd1;
    end
  end

  // State, counter and Moore outputs registered together; each output is a pure
  // function of the state being entered, so it always matches the registered state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      x_sel_q <= 1'b0;
      x_ld_q  <= 1'b0;
      y_sel_q <= 1'b0;
      y_ld_q  <= 1'b0;
      d_ld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      iter_q  <= iter_nxt;
      x_sel_q <= (state_nxt == UPD_X);
      x_ld_q  <= (state_nxt == INIT) || (state_nxt == UPD_X);
      y_sel_q <= (state_nxt == UPD_Y);
      y_ld_q  <= (state_nxt == INIT) || (state_nxt == UPD_Y);
      d_ld_q  <= (state_nxt == LOAD_D);
      busy_q  <= (state_nxt == INIT)  || (state_nxt == CHECK) ||
                 (state_nxt == UPD_X) || (state_nxt == UPD_Y) ||
                 (state_nxt == LOAD_D);
      done_q  <= (state_nxt == DONE) || (state_nxt == ERR);
      err_q   <= (state_nxt == ERR);
    end
  end

  assign bus.x_sel  = x_sel_q;
  assign bus.x_ld   = x_ld_q;
  assign bus.y_sel  = y_sel_q;
  assign bus.y_ld   = y_ld_q;
  assign bus.d_ld   = d_ld_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;
  assign bus.iter_o = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl with a small X/Y/D datapath model around it.
module tb_gcd_ctrl;

  logic CLK;
  logic RESET;
  gcd_ctrl_if bus ();

  gcd_ctrl #(.ITER_MAX(15)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath model driven by the controller's selects/loads.
  logic [7:0] x_i, y_i, xr, yr, d_o;
  always @(posedge CLK) begin
    if (!RESET) begin
      xr  <= 8'd0;
      yr  <= 8'd0;
      d_o <= 8'd0;
    end else begin
      if (bus.x_ld) xr  <= bus.x_sel ? (xr - yr) : x_i;
      if (bus.y_ld) yr  <= bus.y_sel ? (yr - xr) : y_i;
      if (bus.d_ld) d_o <= xr;
    end
  end
  assign bus.x_neq_y = (xr != yr);
  assign bus.x_lt_y  = (xr < yr);

  // {busy, done, err, d_ld, x_ld, x_sel, y_ld, y_sel}
  wire [7:0] outs = {bus.busy_o, bus.done_o, bus.err_o, bus.d_ld,
                     bus.x_ld, bus.x_sel, bus.y_ld, bus.y_sel};

  int n_vec  = 0;
  int n_miss = 0;
  int dld_cnt = 0;
  int excl_viol = 0;

  // Load-exclusivity watch and d_ld pulse counter, sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.d_ld) dld_cnt = dld_cnt + 1;
    if ((bus.d_ld && (bus.x_ld || bus.y_ld)) ||
        (bus.x_sel && bus.x_ld && bus.y_sel && bus.y_ld))
      excl_viol = excl_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output vectors after edges 0..7 of the 8/12 run.
  logic [7:0] seq_8_12 [8] = '{8'h8A, 8'h80, 8'h83, 8'h80, 8'h8C, 8'h80, 8'h90, 8'h40};

  task automatic run_gcd(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input int exp_edge, input logic [3:0] exp_iter,
                         input logic [7:0] exp_d, input logic exp_err,
                         input int hold, input logic chk_seq);
    int edge_n;
    @(negedge CLK);
    x_i = x;
    y_i = y;
    bus.go_i = 1'b1;
    dld_cnt = 0;
    excl_viol = 0;
    edge_n = -1;
    forever begin
      @(posedge CLK);
      edge_n++;
      #1;
      if (chk_seq && edge_n < 8) check({tag, "_seq"}, 32'(outs), 32'(seq_8_12[edge_n]));
      if (bus.done_o) break;
      if (edge_n > 100) begin
        check({tag, "_timeout"}, 32'(edge_n), 32'(exp_edge));
        break;
      end
    end
    check({tag, "_edge"}, 32'(edge_n), 32'(exp_edge));
    check({tag, "_iter"}, 32'(bus.iter_o), 32'(exp_iter));
    check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_dld"}, 32'(dld_cnt), exp_err ? 32'd0 : 32'd1);
    check({tag, "_excl"}, 32'(excl_viol), 32'd0);
    if (!exp_err) check({tag, "_d"}, 32'(d_o), 32'(exp_d));
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      check({tag, "_hold_done"}, 32'(bus.done_o), 32'd1);
      check({tag, "_hold_busy"}, 32'(bus.busy_o), 32'd0);
    end
    bus.go_i = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, "_idle_outs"}, 32'(outs), 32'd0);
    check({tag, "_idle_iter"}, 32'(bus.iter_o), 32'(exp_iter));
  endtask

  initial begin
    RESET = 1'b0;
    bus.go_i = 1'b1;      // reset must win over go
    x_i = 8'd0;
    y_i = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_iter", 32'(bus.iter_o), 32'd0);
    bus.go_i = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_idle", 32'(outs), 32'd0);

    run_gcd("g8_12",  8'd8,  8'd12, 7,  4'd2,  8'd4, 1'b0, 5, 1'b1);
    run_gcd("g15_1",  8'd15, 8'd1,  31, 4'd14, 8'd1, 1'b0, 0, 1'b0);
    run_gcd("g5_0",   8'd5,  8'd0,  32, 4'd15, 8'd0, 1'b1, 2, 1'b0);
    run_gcd("g0_0",   8'd0,  8'd0,  3,  4'd0,  8'd0, 1'b0, 0, 1'b0);

    // Reset while in UPD_Y of an 8/12 run.
    @(negedge CLK);
    x_i = 8'd8;
    y_i = 8'd12;
    bus.go_i = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_updy", 32'(outs), 32'h83);
    check("mid_iter", 32'(bus.iter_o), 32'd1);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_outs", 32'(outs), 32'd0);
    check("mid_rst_iter", 32'(bus.iter_o), 32'd0);
    bus.go_i = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_idle", 32'(outs), 32'd0);
    run_gcd("g8_12b", 8'd8, 8'd12, 7, 4'd2, 8'd4, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 The block SHALL have parameter ITER_MAX, default 15, meaning the maximum number of subtract steps before it aborts with an error.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-004 The block SHALL have port go_i, input, 1 bit: start request, four-phase handshake with done_o.
REQ-005 The block SHALL have port x_neq_y, input, 1 bit: datapath flag, 1 when X register != Y register.
REQ-006 The block SHALL have port x_lt_y, input, 1 bit: datapath flag, 1 when X register < Y register.
REQ-007 The block SHALL have port x_sel, output, 1 bit: X mux select; 0 = x_i, 1 = X-Y.
REQ-008 The block SHALL have port x_ld, output, 1 bit: X register load enable.
REQ-009 The block SHALL have port y_sel, output, 1 bit: Y mux select; 0 = y_i, 1 = Y-X.
REQ-010 The block SHALL have port y_ld, output, 1 bit: Y register load enable.
REQ-011 The block SHALL have port d_ld, output, 1 bit: result register load enable (d_o <= X).
REQ-012 The block SHALL have port busy_o, output, 1 bit: 1 while a computation is in progress.
REQ-013 The block SHALL have port done_o, output, 1 bit: 1 when the result or the error is available.
REQ-014 The block SHALL have port err_o, output, 1 bit: 1 when the run aborted on iteration limit.
REQ-015 The block SHALL have port iter_o, output, 4 bits: number of subtract steps in the current or last run.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, INIT, CHECK, UPD_X, UPD_Y, LOAD_D, DONE, ERR; all outputs decode from registered state only.
REQ-017 IDLE: all load/select outputs are 0; go_i=1 moves to INIT; otherwise stay.
REQ-018 INIT: x_sel=0, y_sel=0, x_ld=1, y_ld=1; iter cleared to 0; next state is CHECK unconditionally.
REQ-019 CHECK: no loads asserted; transitions evaluate in priority order: x_neq_y=0 -> LOAD_D; iter==ITER_MAX -> ERR; x_lt_y=1 -> UPD_Y; else UPD_X.
REQ-020 UPD_X: x_sel=1, x_ld=1, iter+1; UPD_Y: y_sel=1, y_ld=1, iter+1; both return to CHECK.
REQ-021 LOAD_D: d_ld=1 for exactly one cycle, then DONE.
REQ-022 DONE: done_o=1, err_o=0; stay while go_i=1; go_i=0 -> IDLE.
REQ-023 ERR: done_o=1, err_o=1, no loads; stay while go_i=1; go_i=0 -> IDLE.
REQ-024 busy_o SHALL be 1 exactly in INIT, CHECK, UPD_X, UPD_Y, LOAD_D.
REQ-025 With go_i sampled high in IDLE at edge 0 and k subtract steps, DONE SHALL be entered at edge 2k+3.
REQ-026 iter SHALL never wrap: it counts at most to ITER_MAX. It holds its last value through DONE, ERR and IDLE until the next INIT.
REQ-027 x_sel and y_sel SHALL never both be 1 with their loads active in the same cycle, and x_ld/y_ld SHALL never be active with d_ld.
REQ-028 go_i held high after DONE/ERR SHALL NOT start a new run until it has been observed low.
REQ-029 Unreachable state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-030 RESET=0 at a rising edge SHALL force IDLE, iter=0, and all outputs 0, from any state, including mid-computation.
REQ-031 RESET SHALL take priority over go_i; a computation SHALL start only at an edge where RESET=1 and go_i=1 in IDLE.

Verification
REQ-032 The bench SHALL cover this case: datapath x_i=8, y_i=12, go_i pulse held -> states INIT, CHECK, UPD_Y, CHECK, UPD_X, CHECK, LOAD_D, DONE; done_o at edge 7, iter_o=2, d_o=4, err_o=0.
REQ-033 The bench SHALL cover this case: x_i=15, y_i=1 -> 14 subtract steps, done_o at edge 31, iter_o=14, d_o=1, err_o=0.
REQ-034 The bench SHALL cover this case: x_i=5, y_i=0 -> UPD_X repeats, ERR at edge 32, done_o=1, err_o=1, iter_o=15, d_ld never asserted.
REQ-035 The bench SHALL cover this case: x_i=y_i=0 -> INIT, CHECK, LOAD_D, DONE at edge 3, d_o=0, iter_o=0.
REQ-036 The bench SHALL cover this case: RESET driven low during UPD_Y of the 8/12 run -> next edge in IDLE, all outputs 0, iter_o=0; a new go_i runs to d_o=4.
REQ-037 The bench SHALL cover this case: go_i held high through DONE for 5 cycles -> DONE persists, no INIT; go_i low -> IDLE next edge, busy_o=0, done_o=0.
